// File: rtl/nn_pkg.sv
// Shared types and constants for the neural-network layer: sequencer state
// encoding and the default node geometry also used by the MAC datapath.
package nn_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, ACT, DONE} seq_state_t;

    localparam int NN_NUM_INPUTS = 64;
    localparam int NN_CNT_W      = 7;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with synchronous clear; wrap flags the last value so the
// owner can decide what happens when the count rolls back to zero.
module mod_counter #(
    parameter int WIDTH  = 8,
    parameter int MODULO = 256
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

    assign wrap = (count == LAST);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/node_sequencer.sv
// Layer sequencer for the MAC node datapath: clear, accumulate, activate per node.
// Define NODE_SEQ_BIAS_EN to append a bias term (cnt_val == NUM_INPUTS) to each node.
module node_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS = NN_NUM_INPUTS,
    parameter int NUM_NODES  = 16,
    parameter int CNT_W      = NN_CNT_W,
    parameter int NODE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic              data_valid,
    output logic              busy,
    output logic              done,
    output logic              reset_acc,
    output logic              acc_en,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [NODE_W-1:0] node_sel,
    output logic              act_latch
);

`ifdef NODE_SEQ_BIAS_EN
    localparam int TERMS = NUM_INPUTS + 1;
`else
    localparam int TERMS = NUM_INPUTS;
`endif

    seq_state_t state;
    logic       stop;
    logic       cnt_en;
    logic       cnt_wrap;
    logic       node_clr;
    logic       node_en;
    logic       node_wrap;

    // Reset and abort both return the counters to zero so a fresh go starts clean.
    assign stop     = rst || (abort && (state != IDLE));
    assign cnt_en   = (state == ACCUM) && data_valid;
    assign node_clr = stop || (state == DONE);
    assign node_en  = (state == ACT) && !node_wrap;
    assign acc_en   = (state == ACCUM) && data_valid;

    mod_counter #(
        .WIDTH  (CNT_W),
        .MODULO (TERMS)
    ) u_cnt (
        .clk   (clk),
        .clr   (stop),
        .en    (cnt_en),
        .count (cnt_val),
        .wrap  (cnt_wrap)
    );

    mod_counter #(
        .WIDTH  (NODE_W),
        .MODULO (NUM_NODES)
    ) u_node (
        .clk   (clk),
        .clr   (node_clr),
        .en    (node_en),
        .count (node_sel),
        .wrap  (node_wrap)
    );

    // Strobe outputs default low each cycle and are raised only on entry to their state.
    always_ff @(posedge clk) begin
        reset_acc <= 1'b0;
        act_latch <= 1'b0;
        done      <= 1'b0;
        if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go && !abort) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        reset_acc <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= ACCUM;
                end
                ACCUM: begin
                    if (data_valid && cnt_wrap) begin
                        state     <= ACT;
                        act_latch <= 1'b1;
                    end
                end
                ACT: begin
                    if (node_wrap) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= CLEAR;
                        reset_acc <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/node_sequencer.md
Name: node_sequencer

Overview:
- Controller that sequences the fixed-point MAC node datapath for one network layer.
- For each of NUM_NODES nodes it clears the accumulator, steps cnt_val through NUM_INPUTS coefficient/data pairs, then strobes the activation latch.
- Sits between the layer-level top controller (go/done handshake) and the node datapath (reset_acc, start/acc_en, cnt_val, node_sel).
- Handles input stalls and aborts.

Parameters:
- NUM_INPUTS, 64: MAC terms per node; legal range 2..127.
- NUM_NODES, 16: nodes per layer, sequenced one after another; legal range 1..256.
- CNT_W, 7: cnt_val width; must satisfy 2^CNT_W > NUM_INPUTS.
- NODE_W, 8: node_sel width; must satisfy 2^NODE_W >= NUM_NODES.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- go  input  1  start-of-layer request; sampled only in IDLE.
- abort  input  1  cancels the current layer; highest priority after rst.
- data_valid  input  1  coef/data pair at cnt_val is available this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last node's activation is latched.
- reset_acc  output  1  clears the node accumulator.
- acc_en  output  1  accumulates the current product; drives the datapath start.
- cnt_val  output  CNT_W  input index, 0..NUM_INPUTS-1.
- node_sel  output  NODE_W  index of the node being computed.
- act_latch  output  1  one-cycle strobe that captures activation(accumulator) into the node output.

Behaviour:
- Reset: when rst is high at a rising edge, the next state is IDLE and every output is 0. This applies from any state, including mid-layer.
- Outputs are registered. They change only on clk edges and reflect the current state and counters.
- States: IDLE, CLEAR, ACCUM, ACT, DONE.
- IDLE:
  - All outputs 0.
  - go=1 → CLEAR, with node_sel=0 and cnt_val=0.
  - go while busy is ignored; there is no queuing.
- CLEAR:
  - reset_acc=1 for exactly one cycle; cnt_val=0; then → ACCUM.
- ACCUM:
  - acc_en = data_valid.
  - If data_valid=1 and cnt_val<NUM_INPUTS-1: cnt_val increments next cycle.
  - If data_valid=1 and cnt_val==NUM_INPUTS-1: → ACT, and cnt_val wraps to 0.
  - If data_valid=0: stall. cnt_val holds and acc_en=0. Stalls are unbounded.
- ACT:
  - act_latch=1 for one cycle.
  - If node_sel==NUM_NODES-1: → DONE.
  - Otherwise node_sel increments and → CLEAR.
- DONE:
  - done=1 for one cycle, busy still 1; then → IDLE.
  - node_sel returns to 0 on entry to IDLE.
- abort:
  - abort=1 in any non-IDLE state → IDLE next cycle, with all outputs 0.
  - No act_latch or done pulse is issued.
  - abort in IDLE has no effect.
  - abort and go asserted together in IDLE: stay in IDLE.
- Latency, no stalls:
  - go to first acc_en: 2 cycles.
  - Per node: NUM_INPUTS+2 cycles (CLEAR + ACCUM×NUM_INPUTS + ACT).
  - Layer: NUM_NODES×(NUM_INPUTS+2)+1 cycles from go to the done pulse.
- cnt_val never exceeds NUM_INPUTS-1. node_sel never exceeds NUM_NODES-1.

Optional Feature:
- Macro: NODE_SEQ_BIAS_EN.
- When defined:
  - ACCUM runs one extra term, at cnt_val=NUM_INPUTS (the bias slot). The datapath supplies coef=bias and data=1.0.
  - The wrap condition becomes cnt_val==NUM_INPUTS.
  - Per-node time becomes NUM_INPUTS+3 cycles.
  - Requires 2^CNT_W > NUM_INPUTS+1.
- When undefined: the behaviour is exactly as described above.

Decomposition:
- Package nn_pkg holds:
  - typedef enum logic [2:0] seq_state_t {IDLE, CLEAR, ACCUM, ACT, DONE};
  - constants NN_NUM_INPUTS=64 and NN_CNT_W=7, shared with the node datapath.
- Sub-module mod_counter(WIDTH, MODULO) is used for both cnt_val and node_sel. Its ports are clr, en, count, and wrap (combinational flag for the last value).
- The FSM stays in node_sequencer.

Test Plan:
1. NUM_INPUTS=4, NUM_NODES=2, data_valid tied high, go pulse at cycle 0.
   - reset_acc at cycle 1; acc_en at cycles 2-5 with cnt_val 0,1,2,3; act_latch at 6.
   - reset_acc at 7; act_latch at 12; done at 13; busy low at 14.
2. data_valid low for 3 cycles while cnt_val=2:
   - cnt_val holds at 2 and acc_en=0 for those cycles.
   - done arrives exactly 3 cycles later than in scenario 1.
3. abort at cycle 4 of scenario 1:
   - State is IDLE at cycle 5 with all outputs 0; no act_latch or done pulse.
   - A fresh go then restarts from node_sel=0, cnt_val=0.
4. rst high for 1 cycle mid-ACCUM (cnt_val=2, node_sel=1):
   - Next cycle all outputs are 0 and the state is IDLE.
   - go during rst is ignored.
5. go held high continuously and re-pulsed while busy:
   - Exactly one done per layer; after done, IDLE lasts 1 cycle, then the next layer starts.
6. NODE_SEQ_BIAS_EN defined, NUM_INPUTS=4:
   - cnt_val sequence 0..4 per node; act_latch at cycle 7; done at cycle 15.
